seven_segment_scan_ctrl: RTL and testbench
==========================================

Name: seven_segment_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one 7-segment bus (seg_out/dp_out) among NUM_DIGITS common-cathode digits in the user project area. Digit values are double-buffered. Firmware-facing logic writes a shadow bank through a valid/ready port and requests a commit. The shadow bank becomes the active bank only at a frame boundary, so the display never tears. A blanking interval between digits suppresses ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be at least 2.
DIGIT_CYCLES, 1000, clocks each digit is driven; must be at least 1.
BLANK_CYCLES, 16, clocks of all-off before each digit; 0 means no blanking.
CNT_W, 16, phase counter width; must hold max(DIGIT_CYCLES, BLANK_CYCLES).

Ports:
clock  in  1  system clock.
resetb  in  1  asynchronous active-low reset.
enable  in  1  scan enable; level-sensitive.
wr_valid  in  1  shadow write request.
wr_ready  out  1  shadow write accepted when high together with wr_valid.
wr_digit  in  $clog2(NUM_DIGITS)  shadow entry index.
wr_value  in  4  digit code.
wr_dp  in  1  decimal point for the entry.
commit  in  1  single-cycle pulse requesting shadow-to-active swap.
commit_pending  out  1  swap requested but not yet applied.
seg_out  out  7  segments {g,f,e,d,c,b,a}; registered.
dp_out  out  1  decimal point; registered.
digit_en  out  NUM_DIGITS  one-hot digit select, or all-zero; registered.
frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values:
  - All outputs 0; wr_ready = 1.
  - State IDLE, digit index 0, phase counter 0.
  - Every shadow and active entry = value 4'hA (blank), dp = 0.
- Decode (wr_value → seg_out):
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110
  - 5→1101101, 6→1111100, 7→0000111, 8→1111111, 9→1100111
  - 10–14→0000000, 15→1000000 (dash).
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs: digit_en = 0, seg_out = 0, dp_out = 0.
  - enable = 1 → BLANK with idx = 0, or straight to DRIVE if BLANK_CYCLES = 0.
- BLANK:
  - Outputs: digit_en = 0, seg_out = 0.
  - Lasts exactly BLANK_CYCLES clocks, then → DRIVE.
- DRIVE:
  - digit_en = 1<<idx, seg_out = decode(active[idx]), dp_out = active_dp[idx].
  - Lasts exactly DIGIT_CYCLES clocks.
  - Then idx wraps (NUM_DIGITS-1 → 0) and state → BLANK, or → DRIVE if BLANK_CYCLES = 0.
- Frame: NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) clocks.
- frame_done asserts for exactly the cycle in which the last DRIVE clock of idx = NUM_DIGITS-1 is presented on the outputs.
- enable deasserted in any state:
  - → IDLE at the next edge; outputs clear on that edge; idx resets to 0.
  - No partial frame_done.
- Write handshake:
  - Write occurs when wr_valid & wr_ready; shadow[wr_digit] <= {wr_value, wr_dp}.
  - wr_digit ≥ NUM_DIGITS: the write is accepted and discarded.
- Commit:
  - commit = 1 with commit_pending = 0 → commit_pending = 1 next cycle and wr_ready = 0 while pending.
  - commit while already pending: ignored.
  - A write and a commit in the same cycle: the write lands first and is included in the swap.
- Swap:
  - active <= shadow on the same edge that ends the frame (the cycle after frame_done), so the next frame's digit 0 shows new data.
  - In IDLE, the swap happens on the edge after commit_pending rises.
  - The swap clears commit_pending and restores wr_ready = 1.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); any pending commit is lost.

Decomposition:
- Package seven_seg_pkg holds:
  - segment code constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH
  - function seg_decode(logic [3:0]) → logic [6:0]
  - scan state enum {IDLE, BLANK, DRIVE}.
- Sub-module seven_seg_decoder: combinational wrapper over seg_decode, instanced once on the active-bank read mux.
- Scheduler FSM, phase counter and the two banks stay in the top module.

Test Plan:
(Bench parameters: NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=2.)
- Reset, then enable=1:
  - digit_en = 0 for 2 clocks, then 0001 for 4 clocks with seg_out = 0000000 (blank).
  - frame_done first pulses 24 clocks after the first BLANK clock.
- Write digits 0..3 = 1,2,3,4 with dp on digit 2, then commit mid-frame:
  - Current frame unchanged; the next frame shows 0000110, 1011011, 1001111 (dp_out = 1), 1100110 on digit_en 0001, 0010, 0100, 1000.
- wr_valid held through a commit:
  - wr_ready = 0 from the cycle after commit until the swap edge.
  - Shadow unchanged during that window; the write completes on the first cycle wr_ready returns to 1.
- Same-cycle write (digit 0 = 9) and commit: the next frame's digit 0 shows 1100111.
- enable dropped during DRIVE of digit 2:
  - Next edge: digit_en = 0, seg_out = 0, no frame_done.
  - Re-enable restarts at BLANK with idx 0.
- BLANK_CYCLES=0 build: digit_en walks 0001→0010→0100→1000 with no zero gap, 4 clocks each; assert resetb low mid-DRIVE → all outputs 0 asynchronously and commit_pending = 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// the code-to-segment decode function and the scan state encoding.
package seven_seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active high (common cathode).
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [3:0] CODE_BLANK = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd15:   seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational 4-bit digit code to seven-segment pattern decoder.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_decode(code_i);

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-cathode digits over one segment bus,
// with a double-buffered digit bank swapped only at frame boundaries.
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          enable,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [3:0]                    wr_value,
    input  logic                          wr_dp,
    input  logic                          commit,
    output logic                          commit_pending,
    output logic [6:0]                    seg_out,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);

    localparam int unsigned     IdxW       = $clog2(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DriveLast = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BlankLast =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
    localparam logic [4:0]      EntryReset = {CODE_BLANK, 1'b0};

    // Each bank entry is {code[3:0], dp}.
    typedef logic [NUM_DIGITS-1:0][4:0] bank_t;

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    bank_t                   shadow_q, shadow_d;
    bank_t                   active_q, active_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q, frame_done_d;

    logic                    wr_fire;
    logic                    frame_end;
    logic                    swap;
    logic                    drive_d;
    logic [4:0]              rd_entry;
    logic [6:0]              rd_seg;

    // Scheduler next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                end
                BLANK: begin
                    if (cnt_q == BlankLast) begin
                        cnt_d   = '0;
                        state_d = DRIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DriveLast) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
                        state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign wr_ready       = ~pending_q;
    assign commit_pending = pending_q;
    assign wr_fire        = wr_valid & wr_ready;
    assign frame_end      = (state_q == DRIVE) && (idx_q == LastIdx) && (cnt_q == DriveLast);
    // An idle display has no frame to tear, so the swap need not wait.
    assign swap           = pending_q && (frame_end || (state_q == IDLE));

    // Bank and commit bookkeeping; writes are blocked while a swap is pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_fire && (32'(wr_digit) < NUM_DIGITS)) begin
            shadow_d[wr_digit] = {wr_value, wr_dp};
        end
        if (swap) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    // Read from the next-state bank so a swap is visible on the first digit it affects.
    assign rd_entry = active_d[idx_d];

    seven_seg_decoder u_decoder (
        .code_i (rd_entry[4:1]),
        .seg_o  (rd_seg)
    );

    always_comb begin
        drive_d      = (state_d == DRIVE);
        digit_en_d   = drive_d ? (NUM_DIGITS'(1) << idx_d) : '0;
        seg_d        = drive_d ? rd_seg : SEG_BLANK;
        dp_d         = drive_d & rd_entry[0];
        frame_done_d = drive_d && (idx_d == LastIdx) && (cnt_d == DriveLast);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= {NUM_DIGITS{EntryReset}};
            active_q     <= {NUM_DIGITS{EntryReset}};
            pending_q    <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl: a blanking build and a no-blanking build.
module tb_seven_segment_scan_ctrl;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111100;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1100111;
    localparam logic [6:0] SD = 7'b1000000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetb;
    logic       enable, wr_valid, wr_dp, commit;
    logic [1:0] wr_digit;
    logic [3:0] wr_value;
    logic       wr_ready, commit_pending, dp_out, frame_done;
    logic [6:0] seg_out;
    logic [3:0] digit_en;

    logic       enable0, wr_valid0, wr_dp0, commit0;
    logic [1:0] wr_digit0;
    logic [3:0] wr_value0;
    logic       wr_ready0, commit_pending0, dp_out0, frame_done0;
    logic [6:0] seg_out0;
    logic [3:0] digit_en0;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clock          (clock),
        .resetb         (resetb),
        .enable         (enable),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_digit       (wr_digit),
        .wr_value       (wr_value),
        .wr_dp          (wr_dp),
        .commit         (commit),
        .commit_pending (commit_pending),
        .seg_out        (seg_out),
        .dp_out         (dp_out),
        .digit_en       (digit_en),
        .frame_done     (frame_done)
    );

    seven_segment_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (0),
        .CNT_W        (16)
    ) dut0 (
        .clock          (clock),
        .resetb         (resetb),
        .enable         (enable0),
        .wr_valid       (wr_valid0),
        .wr_ready       (wr_ready0),
        .wr_digit       (wr_digit0),
        .wr_value       (wr_value0),
        .wr_dp          (wr_dp0),
        .commit         (commit0),
        .commit_pending (commit_pending0),
        .seg_out        (seg_out0),
        .dp_out         (dp_out0),
        .digit_en       (digit_en0),
        .frame_done     (frame_done0)
    );

    typedef struct {
        logic [3:0] code;
        logic       dp;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [16];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts on the first BLANK cycle of a frame, ends on the first cycle of the next.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] dps);
        logic [6:0]  s [4];
        logic [12:0] exp;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        for (int i = 0; i < 24; i++) begin
            int d;
            d = i / 6;
            if ((i % 6) < 2) exp = '0;
            else exp = {4'(1 << d), s[d], dps[d], 1'(i == 23)};
            check($sformatf("%s cyc%0d", tag, i),
                  {19'b0, digit_en, seg_out, dp_out, frame_done}, {19'b0, exp});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'd0,  1'b0, S0};
        vecs[1]  = '{4'd1,  1'b1, S1};
        vecs[2]  = '{4'd2,  1'b0, S2};
        vecs[3]  = '{4'd3,  1'b1, S3};
        vecs[4]  = '{4'd4,  1'b0, S4};
        vecs[5]  = '{4'd5,  1'b1, S5};
        vecs[6]  = '{4'd6,  1'b0, S6};
        vecs[7]  = '{4'd7,  1'b1, S7};
        vecs[8]  = '{4'd8,  1'b0, S8};
        vecs[9]  = '{4'd9,  1'b1, S9};
        vecs[10] = '{4'd10, 1'b0, 7'b0};
        vecs[11] = '{4'd11, 1'b1, 7'b0};
        vecs[12] = '{4'd12, 1'b0, 7'b0};
        vecs[13] = '{4'd13, 1'b1, 7'b0};
        vecs[14] = '{4'd14, 1'b0, 7'b0};
        vecs[15] = '{4'd15, 1'b1, SD};

        resetb   = 1'b0;
        enable   = 1'b0; wr_valid  = 1'b0; wr_dp  = 1'b0; commit  = 1'b0;
        wr_digit = '0;   wr_value  = '0;
        enable0  = 1'b0; wr_valid0 = 1'b0; wr_dp0 = 1'b0; commit0 = 1'b0;
        wr_digit0 = '0;  wr_value0 = '0;

        #12;
        check("reset outputs", {digit_en, seg_out, dp_out, frame_done}, '0);
        check("reset wr_ready", wr_ready, 1);
        check("reset pending", commit_pending, 0);
        @(negedge clock);
        resetb = 1'b1;
        tick();
        enable = 1'b1;
        tick();

        check_frame("f1 blank", 7'b0, 7'b0, 7'b0, 7'b0, 4'b0000);

        fork
            check_frame("f2 old", 7'b0, 7'b0, 7'b0, 7'b0, 4'b0000);
            begin
                for (int k = 0; k < 4; k++) begin
                    wr_valid = 1'b1;
                    wr_digit = 2'(k);
                    wr_value = 4'(k + 1);
                    wr_dp    = (k == 2);
                    tick();
                end
                wr_valid = 1'b0;
                wr_dp    = 1'b0;
                repeat (6) tick();
                commit = 1'b1;
                tick();
                commit = 1'b0;
                check("mid-frame commit", {wr_ready, commit_pending}, 2'b01);
            end
        join
        check("swap clears pending", {wr_ready, commit_pending}, 2'b10);
        check_frame("f3 new", S1, S2, S3, S4, 4'b0100);

        fork
            begin
                check_frame("f4", S1, S2, S3, S4, 4'b0100);
                check_frame("f5", S1, S2, S3, S4, 4'b0100);
            end
            begin
                commit = 1'b1;
                tick();
                commit   = 1'b0;
                wr_valid = 1'b1;
                wr_digit = 2'd1;
                wr_value = 4'd7;
                wr_dp    = 1'b0;
                for (int k = 1; k < 24; k++) begin
                    check($sformatf("held wr_ready c%0d", k), wr_ready, 0);
                    tick();
                end
                check("wr_ready back", {wr_ready, commit_pending}, 2'b10);
                tick();
                wr_valid = 1'b0;
                tick();
                wr_valid = 1'b1;
                wr_digit = 2'd0;
                wr_value = 4'd9;
                commit   = 1'b1;
                tick();
                wr_valid = 1'b0;
                commit   = 1'b0;
                check("same-cycle pending", commit_pending, 1);
            end
        join
        check_frame("f6", S9, S7, S3, S4, 4'b0100);

        repeat (15) tick();
        check("pre-drop digit2", {digit_en, seg_out, dp_out}, {4'b0100, S3, 1'b1});
        enable = 1'b0;
        tick();
        check("drop outputs", {digit_en, seg_out, dp_out, frame_done}, '0);
        begin
            int fd;
            fd = 0;
            for (int k = 0; k < 30; k++) begin
                fd += int'(frame_done);
                tick();
            end
            check("no frame_done while disabled", fd, 0);
        end
        enable = 1'b1;
        tick();
        check_frame("restart", S9, S7, S3, S4, 4'b0100);
        enable = 1'b0;
        tick();

        for (int v = 0; v < 16; v++) begin
            wr_valid = 1'b1;
            wr_digit = 2'd0;
            wr_value = vecs[v].code;
            wr_dp    = vecs[v].dp;
            commit   = 1'b1;
            tick();
            wr_valid = 1'b0;
            commit   = 1'b0;
            check($sformatf("idle pending v%0d", v), commit_pending, 1);
            tick();
            check($sformatf("idle swap v%0d", v), commit_pending, 0);
            enable = 1'b1;
            repeat (3) tick();
            check($sformatf("decode v%0d", v), {digit_en, seg_out, dp_out},
                  {4'b0001, vecs[v].seg, vecs[v].dp});
            enable = 1'b0;
            tick();
        end

        wr_valid0 = 1'b1;
        wr_digit0 = 2'd0;
        wr_value0 = 4'd8;
        wr_dp0    = 1'b1;
        commit0   = 1'b1;
        tick();
        wr_valid0 = 1'b0;
        commit0   = 1'b0;
        tick();
        enable0 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("noblank walk cyc%0d", i),
                  {digit_en0, seg_out0, dp_out0, frame_done0},
                  {4'(1 << (i / 4)), (i < 4) ? S8 : 7'b0, 1'(i < 4), 1'(i == 15)});
            tick();
        end
        commit0 = 1'b1;
        tick();
        commit0 = 1'b0;
        check("noblank pending", commit_pending0, 1);
        tick();
        check("noblank pre-reset", {digit_en0, seg_out0, dp_out0}, {4'b0001, S8, 1'b1});
        #3;
        resetb = 1'b0;
        #1;
        check("async reset outputs", {digit_en0, seg_out0, dp_out0, frame_done0}, '0);
        check("async reset handshake", {wr_ready0, commit_pending0}, 2'b10);
        #10;
        resetb = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
